norm_shift_ctrl: RTL and testbench
==================================

# norm_shift_ctrl

Pipelined normalization shift controller for the FPU add/subtract datapath. It takes the raw significand sum and its tentative exponent, and finds either a carry-out or the leading-one position. From that it produces the shift amount and direction for the significand barrel shifter, the adjusted exponent, and the zero, overflow and underflow flags. It sits between the significand adder and the normalization shifter, on the control side of the shifter interface. Two register stages with valid/ready handshaking on both sides.

## Interface
- SWR, 26, significand working width; bit SWR-1 is the adder carry-out bit.
- EW, 8, exponent width.
- SHW, 5, shift-amount width; must satisfy 2^SHW > SWR-2.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid_i  in  1  Data_i/Exp_i valid.
- in_ready_o  out  1  block accepts input this cycle.
- Data_i  in  SWR  raw significand sum.
- Exp_i  in  EW  tentative (larger-operand) exponent.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts result.
- Shift_Value_o  out  SHW  shift amount for the barrel shifter.
- Left_Right_o  out  1  1 = left shift, 0 = right shift.
- Exp_o  out  EW  adjusted exponent.
- Zero_o, Overflow_o, Underflow_o  out  1 each  result flags.

## Operation
- Accept rule: a transfer occurs when in_valid_i && in_ready_o at a rising edge.
- Stage 1 registers, for each accepted transfer:
  - carry = Data_i[SWR-1];
  - zero = (Data_i == 0);
  - lz = count of zeros from bit SWR-2 downward to the first 1 (0..SWR-2; forced to 0 when zero);
  - Exp_i.
- Stage 2 computes from stage 1, in priority order:
  - zero: Shift_Value_o=0, Left_Right_o=1, Exp_o=0, Zero_o=1.
  - carry: Shift_Value_o=1, Left_Right_o=0, Exp_o=Exp+1 (mod 2^EW). Overflow_o=1 iff Exp+1 == all-ones; Exp_o is then all-ones.
  - otherwise: Shift_Value_o=lz, Left_Right_o=1.
    - If lz >= Exp: Underflow_o=1, Exp_o=0.
    - Else: Exp_o=Exp-lz.
  - At most one of Zero_o, Overflow_o, Underflow_o is 1.
- Flow control:
  - Each stage has a valid bit.
  - Stage 2 loads when empty or when out_ready_i=1.
  - Stage 1 advances into stage 2 whenever stage 2 loads.
  - in_ready_o = !s1_valid || stage-2-loads. Combinational from state and out_ready_i; no dependency on in_valid_i.
- Ordering: results emerge in acceptance order; none dropped or duplicated.

## Timing
- Latency: input accepted at edge k gives out_valid_o=1 after edge k+1 when the pipeline is unstalled (visible in the cycle following edge k+1).
- Throughput: one result per cycle with out_ready_i held 1.
- Stall: while out_valid_o=1 && out_ready_i=0, all result outputs hold stable. Up to 2 transfers are buffered; in_ready_o drops to 0 when both stages are full.
- Simultaneous pop and push while full: allowed in the same cycle; no bubble.
- Reset (rst=0, any time, including mid-transfer):
  - both valid bits clear;
  - out_valid_o=0;
  - Shift_Value_o=0, Left_Right_o=0, Exp_o=0, all flags 0;
  - in_ready_o=1 on the first cycle after rst deasserts;
  - in-flight data is discarded.
- No combinational path from Data_i/Exp_i to any output.

## Test plan
All cases use SWR=26, EW=8, SHW=5, out_ready_i=1 unless stated.
- Carry case: Data_i=0x2000000, Exp_i=0x80 -> Shift_Value_o=1, Left_Right_o=0, Exp_o=0x81, all flags 0; out_valid_o 2 edges after accept.
- Exactly normalized and deep left shift:
  - Data_i=0x1000000, Exp_i=0x80 -> shift 0, left, Exp_o=0x80.
  - Data_i=0x0000001, Exp_i=0x80 -> shift 24, left, Exp_o=0x68.
- Boundaries:
  - Data_i=0 -> Zero_o=1, shift 0, Exp_o=0.
  - Data_i=0x2000000, Exp_i=0xFE -> Exp_o=0xFF, Overflow_o=1.
  - Data_i=0x0000100, Exp_i=0x05 -> shift 16, left, Underflow_o=1, Exp_o=0.
- Backpressure:
  - 4 back-to-back inputs with out_ready_i=0 for 5 cycles -> exactly 2 accepted, in_ready_o=0 until out_ready_i rises;
  - outputs stable while stalled;
  - all 4 results delivered in order with no loss.
- Streaming: 100 random inputs with random out_ready_i -> every result matches a reference model, in order, count equal.
- Reset mid-operation: assert rst with both stages full -> out_valid_o=0 and all outputs 0 immediately (asynchronous); in_ready_o=1 after release; the next input produces a correct result with no stale data.

Source files
------------

// File: rtl/norm_shift_ctrl.sv
// norm_shift_ctrl: two-stage normalization shift controller (carry / leading-zero detect, exponent adjust, flags)
module norm_shift_ctrl #(
    parameter int SWR = 26,
    parameter int EW  = 8,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [SWR-1:0] Data_i,
    input  logic [EW-1:0]  Exp_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [SHW-1:0] Shift_Value_o,
    output logic           Left_Right_o,
    output logic [EW-1:0]  Exp_o,
    output logic           Zero_o,
    output logic           Overflow_o,
    output logic           Underflow_o
);
    logic           s1_valid, s1_carry, s1_zero;
    logic [SHW-1:0] s1_lz;
    logic [EW-1:0]  s1_exp;
    logic           s2_load, in_fire, found;
    logic [SHW-1:0] lz;
    logic [SHW-1:0] n_sh;
    logic           n_lr, n_ov, n_uf;
    logic [EW-1:0]  n_exp, e_inc;

    assign s2_load    = !out_valid_o || out_ready_i;
    assign in_ready_o = !s1_valid || s2_load;
    assign in_fire    = in_valid_i && in_ready_o;

    // leading zeros below the carry bit
    always_comb begin
        lz    = '0;
        found = 1'b0;
        for (int i = SWR - 2; i >= 0; i--) begin
            if (!found && Data_i[i]) found = 1'b1;
            else if (!found) lz = lz + SHW'(1);
        end
        if (Data_i == '0) lz = '0;
    end

    always_comb begin
        e_inc = s1_exp + EW'(1);
        n_sh  = s1_zero ? '0 : s1_carry ? SHW'(1) : s1_lz;
        n_lr  = s1_zero || !s1_carry;
        n_ov  = !s1_zero && s1_carry && (e_inc == '1);
        n_uf  = !s1_zero && !s1_carry && (EW'(s1_lz) >= s1_exp);
        n_exp = (s1_zero || n_uf) ? '0 : s1_carry ? e_inc : s1_exp - EW'(s1_lz);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid      <= 1'b0;
            s1_carry      <= 1'b0;
            s1_zero       <= 1'b0;
            s1_lz         <= '0;
            s1_exp        <= '0;
            out_valid_o   <= 1'b0;
            Shift_Value_o <= '0;
            Left_Right_o  <= 1'b0;
            Exp_o         <= '0;
            Zero_o        <= 1'b0;
            Overflow_o    <= 1'b0;
            Underflow_o   <= 1'b0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                s1_carry <= Data_i[SWR-1];
                s1_zero  <= (Data_i == '0);
                s1_lz    <= lz;
                s1_exp   <= Exp_i;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (s2_load) begin
                out_valid_o <= s1_valid;
                if (s1_valid) begin
                    Shift_Value_o <= n_sh;
                    Left_Right_o  <= n_lr;
                    Exp_o         <= n_exp;
                    Zero_o        <= s1_zero;
                    Overflow_o    <= n_ov;
                    Underflow_o   <= n_uf;
                end
            end
        end
    end
endmodule

// File: tb/tb_norm_shift_ctrl.sv
// tb_norm_shift_ctrl: vector table, backpressure, streaming and reset checks with a scoreboard queue
module tb_norm_shift_ctrl;
    typedef struct packed {
        logic [4:0] sh;
        logic       lr;
        logic [7:0] e;
        logic       z, o, u;
    } out_t;
    typedef struct {
        logic [25:0] d;
        logic [7:0]  e;
        out_t        x;
    } vec_t;

    logic        clk = 0, rst = 0, in_valid = 0, in_ready, out_valid, out_ready = 1;
    logic [25:0] Data = '0;
    logic [7:0]  Exp = '0;
    logic [4:0]  sh;
    logic        lr, zf, of, uf;
    logic [7:0]  eo;
    out_t        cur_exp, held, got;
    out_t        q[$];
    int          asserts = 0, fails = 0, n_acc = 0, n_out = 0;
    logic        rand_mode = 0, hold_chk = 0;
    vec_t        tbl[10];

    norm_shift_ctrl dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .Data_i(Data), .Exp_i(Exp), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .Shift_Value_o(sh), .Left_Right_o(lr), .Exp_o(eo),
        .Zero_o(zf), .Overflow_o(of), .Underflow_o(uf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        asserts++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, a, x);
        end
    endtask

    function automatic out_t model(input logic [25:0] d, input logic [7:0] e);
        out_t r = '0;
        int   pos = -1, lzv;
        for (int i = 0; i < 25; i++) if (d[i]) pos = i;
        if (d == 0) begin
            r.lr = 1; r.z = 1;
        end else if (d[25]) begin
            r.sh = 1; r.e = e + 8'd1; r.o = (e == 8'hFE);
        end else begin
            lzv = 24 - pos;
            r.sh = 5'(lzv); r.lr = 1;
            if (lzv >= int'(e)) r.u = 1;
            else r.e = 8'(int'(e) - lzv);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        got = {sh, lr, eo, zf, of, uf};
        if (!rst) hold_chk <= 0;
        else begin
            if (hold_chk && out_valid) chk("stall_hold", 32'(got), 32'(held));
            hold_chk <= out_valid && !out_ready;
            held <= got;
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) chk("unexpected_out", 1, 0);
                else chk("result", 32'(got), 32'(q.pop_front()));
            end
            if (in_valid && in_ready) begin
                q.push_back(cur_exp);
                n_acc++;
            end
        end
    end

    task automatic rnd_rdy();
        if (rand_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [25:0] d, input logic [7:0] e, input out_t x);
        int t = 0;
        Data = d; Exp = e; cur_exp = x; in_valid = 1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
            rnd_rdy();
            if (++t > 200) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        in_valid = 0;
        rnd_rdy();
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 1000) begin
            @(posedge clk); #1;
            rnd_rdy();
            t++;
        end
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        out_ready = 1;
    endtask

    logic [25:0] bd[4];
    logic [7:0]  be[4];
    int          idx, acc;
    logic        adv;
    logic [25:0] rd;
    logic [7:0]  re;

    initial begin
        tbl[0] = '{26'h2000000, 8'h80, '{5'd1,  1'b0, 8'h81, 1'b0, 1'b0, 1'b0}};
        tbl[1] = '{26'h1000000, 8'h80, '{5'd0,  1'b1, 8'h80, 1'b0, 1'b0, 1'b0}};
        tbl[2] = '{26'h0000001, 8'h80, '{5'd24, 1'b1, 8'h68, 1'b0, 1'b0, 1'b0}};
        tbl[3] = '{26'h0000000, 8'h80, '{5'd0,  1'b1, 8'h00, 1'b1, 1'b0, 1'b0}};
        tbl[4] = '{26'h2000000, 8'hFE, '{5'd1,  1'b0, 8'hFF, 1'b0, 1'b1, 1'b0}};
        tbl[5] = '{26'h0000100, 8'h05, '{5'd16, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1}};
        tbl[6] = '{26'h3FFFFFF, 8'hFF, '{5'd1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0}};
        tbl[7] = '{26'h0800000, 8'h01, '{5'd1,  1'b1, 8'h00, 1'b0, 1'b0, 1'b1}};
        tbl[8] = '{26'h0800000, 8'h02, '{5'd1,  1'b1, 8'h01, 1'b0, 1'b0, 1'b0}};
        tbl[9] = '{26'h0003000, 8'h40, '{5'd11, 1'b1, 8'h35, 1'b0, 1'b0, 1'b0}};

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_outputs", 32'({sh, lr, eo, zf, of, uf}), 0);
        @(posedge clk); #1;
        rst = 1;
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 10; i++) send(tbl[i].d, tbl[i].e, tbl[i].x);
        drain();

        // latency: accept at edge k, valid visible after edge k+1
        @(posedge clk); #1;
        Data = 26'h2000000; Exp = 8'h80; cur_exp = model(Data, Exp); in_valid = 1;
        @(negedge clk);
        chk("lat_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 0;
        chk("lat_k", out_valid, 0);
        @(posedge clk); #1;
        chk("lat_k1", out_valid, 1);
        drain();

        bd = '{26'h2000000, 26'h1000000, 26'h0000010, 26'h0000000};
        be = '{8'h10, 8'h22, 8'h30, 8'h44};
        out_ready = 0; idx = 0; acc = 0;
        Data = bd[0]; Exp = be[0]; cur_exp = model(bd[0], be[0]); in_valid = 1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            adv = in_ready;
            if (adv) acc++;
            @(posedge clk); #1;
            if (adv) begin
                idx++;
                Data = bd[idx]; Exp = be[idx]; cur_exp = model(bd[idx], be[idx]);
            end
        end
        chk("bp_accepted", acc, 2);
        chk("bp_in_ready", in_ready, 0);
        in_valid = 0;
        out_ready = 1;
        for (int i = idx; i < 4; i++) send(bd[i], be[i], model(bd[i], be[i]));
        drain();

        rand_mode = 1;
        for (int i = 0; i < 100; i++) begin
            rd = 26'($urandom) >> $urandom_range(0, 25);
            re = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 24)) : 8'($urandom);
            send(rd, re, model(rd, re));
        end
        drain();
        rand_mode = 0;
        chk("stream_count", n_out, n_acc);

        out_ready = 0;
        send(26'h0000400, 8'h90, model(26'h0000400, 8'h90));
        send(26'h2000000, 8'h33, model(26'h2000000, 8'h33));
        #2 rst = 0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_outputs", 32'({sh, lr, eo, zf, of, uf}), 0);
        q.delete();
        @(posedge clk); #1;
        rst = 1;
        out_ready = 1;
        chk("arst_in_ready", in_ready, 1);
        send(26'h0040000, 8'h20, model(26'h0040000, 8'h20));
        drain();
        chk("arst_drained", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
